vga_stream_gen: RTL and testbench
=================================

Name: vga_stream_gen

Overview:
- Produces the 23-bit VGA pixel stream consumed by every pixel-stream stage, including the ball/paddle game stage. That stream carries Active, VS, HS, YC and XC.
- Contains the horizontal and vertical raster counters and decodes blanking and sync from them.
- Sits at the head of the pixel pipeline. Its output feeds game/draw stages, whose RGB stream goes to the pin driver.

Parameters:
- H_VISIBLE, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of HS (0 = active-low)
- VS_POL, 0, asserted level of VS

Ports:
- px_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- px_en  in  1  pixel clock enable; all state advances only when 1
- VGAStr_o  out  23  stream: [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC
- line_start_o  out  1  high while VGAStr_o has XC=0
- frame_start_o  out  1  high while VGAStr_o has XC=0 and YC=0

Behaviour:
- Clock and reset: one clock (px_clk). Reset is asynchronous, active-low (rst_n).
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = sum of the V parameters (525). Both must be ≤ 1024. This is an elaboration-time check; it fails if violated.
- Counters: internal hc and vc, 10 bits each, unsigned.
  - On px_clk with px_en=1: if hc = H_TOTAL-1, hc←0 and vc advances; otherwise hc←hc+1.
  - vc advance: if vc = V_TOTAL-1, vc←0; otherwise vc←vc+1.
  - No other wrap points. hc and vc never leave 0..TOTAL-1.
- Output register (1 enabled-cycle latency): on the same enabled edge, VGAStr_o is loaded from the pre-increment hc/vc.
  - XC←hc, YC←vc.
  - Active←(hc<H_VISIBLE && vc<V_VISIBLE).
  - HS←HS_POL if H_VISIBLE+H_FP ≤ hc < H_VISIBLE+H_FP+H_SYNC (656..751), else ~HS_POL.
  - VS←VS_POL if V_VISIBLE+V_FP ≤ vc < V_VISIBLE+V_FP+V_SYNC (490..491), else ~VS_POL.
  - VS is a function of vc only. It changes together with XC=0, not at the HS edge.
  - line_start_o←(hc==0); frame_start_o←(hc==0 && vc==0). Both are registered alongside VGAStr_o.
- Coordinates run through blanking: XC takes 0..799 and YC takes 0..524. Downstream end-of-frame detection (XC=639, YC=479) depends on this.
- px_en=0: counters and all outputs hold their values, including single-cycle flags.
- Reset state (asynchronous, while rst_n=0):
  - hc=0, vc=0.
  - VGAStr_o: XC=0, YC=0, Active=0, HS=~HS_POL, VS=~VS_POL.
  - line_start_o=0, frame_start_o=0.
- After reset deasserts: the first enabled edge outputs XC=0, YC=0, Active=1, with line_start_o=1 and frame_start_o=1.
- Reset mid-frame: immediate return to the reset state. There is no partial-frame recovery; the raster restarts at (0,0).
- Continuous enable: Active high for exactly 640×480 cycles per 420000-cycle frame.
  - HS asserted 96 cycles per line.
  - VS asserted 1600 cycles per frame.

Decomposition:
- Shared package vga_stream_pkg:
  - field bit positions: ACTIVE=0, VS=1, HS=2, YC_LO=3, YC_HI=12, XC_LO=13, XC_HI=22.
  - RGB positions: R=23, G=24, B=25.
  - stream widths: 23 and 26.
  - default 640×480 timing constants.
- The draw stages import the same package, replacing local aliases.
- One sub-module, vga_axis_counter, instantiated twice (H and V).
  - Parameters: TOTAL.
  - Ports: clock, rst_n, enable, count_o, wrap_o.
  - The H instance's wrap_o combined with px_en drives the V instance's enable.

Test Plan:
- Reset then px_en=1 → first output XC=0, YC=0, Active=1, HS=1, VS=1, frame_start_o=1; next cycle XC=1, frame_start_o=0.
- Line 0 scan → Active falls when XC=640; HS=0 exactly for XC 656..751; line_start_o=1 only at XC=0; XC=799 followed by XC=0, YC=1.
- Full frame → VS=0 exactly for YC 490..491; YC=524, XC=799 followed by XC=0, YC=0 with frame_start_o=1; frame length 420000 enabled cycles.
- px_en toggled 1/0 every cycle → output advances once per two clocks; frame length 840000 clocks; values identical to continuous run.
- Assert rst_n=0 asynchronously at XC=300, YC=200 between clock edges → outputs reach the reset state immediately; release → raster restarts at (0,0).
- Variant HS_POL=1, VS_POL=1 → HS=1 only for XC 656..751; VS=1 only for YC 490..491; reset HS=0, VS=0.

Source files
------------

// File: rtl/vga_stream_pkg.sv
// Shared definitions for the VGA pixel stream: field positions, stream widths,
// default 640x480 timing and a small window-decode helper.
package vga_stream_pkg;

  // Bit positions inside the 23-bit raster stream
  localparam int STR_ACTIVE = 0;
  localparam int STR_VS     = 1;
  localparam int STR_HS     = 2;
  localparam int STR_YC_LO  = 3;
  localparam int STR_YC_HI  = 12;
  localparam int STR_XC_LO  = 13;
  localparam int STR_XC_HI  = 22;

  // Colour bits appended by the draw stages (26-bit RGB stream)
  localparam int STR_R = 23;
  localparam int STR_G = 24;
  localparam int STR_B = 25;

  localparam int VGA_STR_W = 23;
  localparam int RGB_STR_W = 26;

  // Default 640x480 @ 60 Hz timing
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  // Half-open window test lo <= v < hi; 11 bits so a bound of 1024 still fits
  function automatic logic in_window(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis counter: counts 0..TOTAL-1 while enabled and flags the last
// position so the next axis can advance on the wrap.
module vga_axis_counter #(
  parameter int TOTAL = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [9:0] count_o,
  output logic       wrap_o
);

  localparam logic [9:0] LAST = 10'(TOTAL - 1);

  assign wrap_o = (count_o == LAST);

  // Advance or wrap on every enabled edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (enable) begin
      count_o <= wrap_o ? 10'd0 : count_o + 10'd1;
    end
  end

endmodule

// File: rtl/vga_stream_gen.sv
// Head of the pixel pipeline: horizontal/vertical raster counters plus a
// registered decode of blanking and sync into the 23-bit VGA stream.
module vga_stream_gen
  import vga_stream_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic        px_en,
  output logic [22:0] VGAStr_o,
  output logic        line_start_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so neither axis may exceed 1024 positions
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_stream_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  localparam logic [10:0] H_ACT_END = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYN_LO  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYN_HI  = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYN_LO  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYN_HI  = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_wrap;
  logic       v_wrap;
  logic       v_en;

  // Vertical axis steps only on the enabled edge that wraps the line
  assign v_en = px_en & h_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk     (px_clk),
    .rst_n   (rst_n),
    .enable  (px_en),
    .count_o (hc),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk     (px_clk),
    .rst_n   (rst_n),
    .enable  (v_en),
    .count_o (vc),
    .wrap_o  (v_wrap)
  );

  logic [VGA_STR_W-1:0] str_p0;
  logic                 line_p0;
  logic                 frame_p0;
  logic                 unused_v_wrap;

  assign unused_v_wrap = v_wrap;

  // Stage 0: combinational decode of the current (pre-increment) position
  always_comb begin
    str_p0                        = '0;
    str_p0[STR_XC_HI:STR_XC_LO]   = hc;
    str_p0[STR_YC_HI:STR_YC_LO]   = vc;
    str_p0[STR_ACTIVE]            = in_window({1'b0, hc}, 11'd0, H_ACT_END) &&
                                    in_window({1'b0, vc}, 11'd0, V_ACT_END);
    str_p0[STR_HS]                = in_window({1'b0, hc}, H_SYN_LO, H_SYN_HI) ?
                                    HS_POL : ~HS_POL;
    str_p0[STR_VS]                = in_window({1'b0, vc}, V_SYN_LO, V_SYN_HI) ?
                                    VS_POL : ~VS_POL;
    line_p0                       = (hc == 10'd0);
    frame_p0                      = (hc == 10'd0) && (vc == 10'd0);
  end

  logic [VGA_STR_W-1:0] str_p1;
  logic                 line_p1;
  logic                 frame_p1;

  // Stage 1: output register, loaded together with the counter advance
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      str_p1         <= '0;
      str_p1[STR_HS] <= ~HS_POL;
      str_p1[STR_VS] <= ~VS_POL;
      line_p1        <= 1'b0;
      frame_p1       <= 1'b0;
    end else if (px_en) begin
      str_p1   <= str_p0;
      line_p1  <= line_p0;
      frame_p1 <= frame_p0;
    end
  end

  assign VGAStr_o      = str_p1;
  assign line_start_o  = line_p1;
  assign frame_start_o = frame_p1;

endmodule

// File: tb/tb_vga_stream_gen.sv
// Bench for vga_stream_gen: a default-timing instance plus two small-raster
// instances (normal and inverted sync polarity) driven from shared stimulus.
module tb_vga_stream_gen;

  logic px_clk = 1'b0;
  logic rst_n  = 1'b1;
  logic px_en  = 1'b0;

  logic [22:0] str_a, str_b, str_c;
  logic        ls_a, fs_a, ls_b, fs_b, ls_c, fs_c;

  always #5 px_clk = ~px_clk;

  vga_stream_gen u_dut_a (
    .px_clk(px_clk), .rst_n(rst_n), .px_en(px_en),
    .VGAStr_o(str_a), .line_start_o(ls_a), .frame_start_o(fs_a)
  );

  // Small raster: H 8/2/3/2 (15), V 6/1/2/2 (11), frame = 165 cycles
  vga_stream_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_b (
    .px_clk(px_clk), .rst_n(rst_n), .px_en(px_en),
    .VGAStr_o(str_b), .line_start_o(ls_b), .frame_start_o(fs_b)
  );

  vga_stream_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_c (
    .px_clk(px_clk), .rst_n(rst_n), .px_en(px_en),
    .VGAStr_o(str_c), .line_start_o(ls_c), .frame_start_o(fs_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int f_xc(input logic [22:0] s); return int'(s[22:13]); endfunction
  function automatic int f_yc(input logic [22:0] s); return int'(s[12:3]);  endfunction

  // Expected stream word for a raster position, straight from the timing numbers
  function automatic logic [22:0] exp_str(input int x, input int y,
                                          input int hv, input int hf, input int hs,
                                          input int vv, input int vf, input int vs,
                                          input bit hpol, input bit vpol);
    logic [22:0] s;
    s        = '0;
    s[22:13] = 10'(x);
    s[12:3]  = 10'(y);
    s[0]     = (x < hv) && (y < vv);
    s[2]     = (x >= hv + hf && x < hv + hf + hs) ? hpol : ~hpol;
    s[1]     = (y >= vv + vf && y < vv + vf + vs) ? vpol : ~vpol;
    return s;
  endfunction

  function automatic int bad_small(input logic [22:0] s, input logic ls, input logic fs,
                                   input int k, input bit pol);
    int x, y;
    x = k % 15;
    y = (k / 15) % 11;
    return (s !== exp_str(x, y, 8, 2, 3, 6, 1, 2, pol, pol) ||
            ls !== (x == 0) || fs !== (x == 0 && y == 0)) ? 1 : 0;
  endfunction

  initial begin
    int bad_a, bad_b, bad_c, bad_t;
    int act_a, hs_a, act_b, vs_b, vs_c, hs_b, hs_c;
    int ax, ay, fs_clk;
    bad_a = 0; bad_b = 0; bad_c = 0; bad_t = 0;
    act_a = 0; hs_a = 0; act_b = 0; vs_b = 0; vs_c = 0; hs_b = 0; hs_c = 0;
    fs_clk = -1;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge px_clk);
    chk("rst_a_xc", f_xc(str_a), 0);
    chk("rst_a_yc", f_yc(str_a), 0);
    chk("rst_a_active", int'(str_a[0]), 0);
    chk("rst_a_hs", int'(str_a[2]), 1);
    chk("rst_a_vs", int'(str_a[1]), 1);
    chk("rst_a_ls", int'(ls_a), 0);
    chk("rst_a_fs", int'(fs_a), 0);
    chk("rst_c_hs", int'(str_c[2]), 0);
    chk("rst_c_vs", int'(str_c[1]), 0);

    // Continuous enable: 3 lines of A, ~14 frames of B/C
    rst_n = 1'b1;
    px_en = 1'b1;
    for (int k = 0; k < 2400; k++) begin
      @(negedge px_clk);
      ax = k % 800;
      ay = (k / 800) % 525;
      if (str_a !== exp_str(ax, ay, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0) ||
          ls_a !== (ax == 0) || fs_a !== (ax == 0 && ay == 0)) bad_a++;
      bad_b += bad_small(str_b, ls_b, fs_b, k, 1'b0);
      bad_c += bad_small(str_c, ls_c, fs_c, k, 1'b1);
      if (k < 800) begin
        act_a += int'(str_a[0]);
        hs_a  += int'(!str_a[2]);
      end
      if (k < 165) begin
        act_b += int'(str_b[0]);
        vs_b  += int'(!str_b[1]);
        vs_c  += int'(str_c[1]);
      end
      if (k < 15) begin
        hs_b += int'(!str_b[2]);
        hs_c += int'(str_c[2]);
      end
      case (k)
        0: begin
          chk("first_xc", f_xc(str_a), 0);
          chk("first_yc", f_yc(str_a), 0);
          chk("first_active", int'(str_a[0]), 1);
          chk("first_hs", int'(str_a[2]), 1);
          chk("first_vs", int'(str_a[1]), 1);
          chk("first_fs", int'(fs_a), 1);
          chk("first_ls", int'(ls_a), 1);
        end
        1: begin
          chk("second_xc", f_xc(str_a), 1);
          chk("second_fs", int'(fs_a), 0);
          chk("second_ls", int'(ls_a), 0);
        end
        104: chk("b_vs_y6", int'(str_b[1]), 1);
        105: chk("b_vs_y7", int'(str_b[1]), 0);
        135: chk("b_vs_y9", int'(str_b[1]), 1);
        164: begin
          chk("b_last_xc", f_xc(str_b), 14);
          chk("b_last_yc", f_yc(str_b), 10);
        end
        165: begin
          chk("b_wrap_xc", f_xc(str_b), 0);
          chk("b_wrap_yc", f_yc(str_b), 0);
          chk("b_wrap_fs", int'(fs_b), 1);
        end
        639: chk("a_active_x639", int'(str_a[0]), 1);
        640: chk("a_active_x640", int'(str_a[0]), 0);
        655: chk("a_hs_x655", int'(str_a[2]), 1);
        656: chk("a_hs_x656", int'(str_a[2]), 0);
        751: chk("a_hs_x751", int'(str_a[2]), 0);
        752: chk("a_hs_x752", int'(str_a[2]), 1);
        799: chk("a_x799", f_xc(str_a), 799);
        800: begin
          chk("a_newline_xc", f_xc(str_a), 0);
          chk("a_newline_yc", f_yc(str_a), 1);
          chk("a_newline_ls", int'(ls_a), 1);
          chk("a_newline_fs", int'(fs_a), 0);
        end
        default: ;
      endcase
    end
    chk("a_stream_mismatches", bad_a, 0);
    chk("b_stream_mismatches", bad_b, 0);
    chk("c_stream_mismatches", bad_c, 0);
    chk("a_active_line0", act_a, 640);
    chk("a_hs_line0", hs_a, 96);
    chk("b_active_frame", act_b, 48);
    chk("b_vs_frame", vs_b, 30);
    chk("c_vs_frame", vs_c, 30);
    chk("b_hs_line", hs_b, 3);
    chk("c_hs_line", hs_c, 3);

    // Enable toggled 1/0: output advances once per two clocks, flags hold
    @(negedge px_clk);
    rst_n = 1'b0;
    px_en = 1'b0;
    @(negedge px_clk);
    rst_n = 1'b1;
    for (int c = 0; c < 700; c++) begin
      px_en = (c % 2 == 0);
      @(negedge px_clk);
      bad_t += bad_small(str_b, ls_b, fs_b, c / 2, 1'b0);
      if (c > 1 && fs_b && fs_clk < 0) fs_clk = c;
    end
    chk("toggle_mismatches", bad_t, 0);
    chk("toggle_frame_clocks", fs_clk, 330);

    // Asynchronous reset between clock edges in mid-frame
    px_en = 1'b1;
    rst_n = 1'b0;
    @(negedge px_clk);
    rst_n = 1'b1;
    repeat (101) @(negedge px_clk);
    chk("pre_rst_xc", f_xc(str_b), 10);
    chk("pre_rst_yc", f_yc(str_b), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_xc", f_xc(str_b), 0);
    chk("async_rst_yc", f_yc(str_b), 0);
    chk("async_rst_active", int'(str_b[0]), 0);
    chk("async_rst_hs", int'(str_b[2]), 1);
    chk("async_rst_vs", int'(str_b[1]), 1);
    chk("async_rst_ls", int'(ls_b), 0);
    chk("async_rst_fs", int'(fs_b), 0);
    chk("async_rst_a_xc", f_xc(str_a), 0);
    @(negedge px_clk);
    rst_n = 1'b1;
    @(negedge px_clk);
    chk("restart_xc", f_xc(str_b), 0);
    chk("restart_yc", f_yc(str_b), 0);
    chk("restart_active", int'(str_b[0]), 1);
    chk("restart_fs", int'(fs_b), 1);
    @(negedge px_clk);
    chk("restart_next_xc", f_xc(str_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
